// File: rtl/bsearch_pkg.sv
// Shared types for the binary-search engine: FSM state encoding and search mode.
package bsearch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef enum logic {
    MODE_EXACT = 1'b0,
    MODE_LOWER = 1'b1
  } mode_t;

endpackage

// File: rtl/bsearch_if.sv
// Request/result and RAM read-port bundle of the search engine.
interface bsearch_if
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  mode_t             mode;
  logic [DATA_W-1:0] key;
  logic [ADDR_W:0]   n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W:0]   index;
  logic [ADDR_W:0]   probes;

  modport master (
    output start, mode, key, n, ram_data,
    input  ram_addr, busy, done, found, index, probes
  );

  modport slave (
    input  start, mode, key, n, ram_data,
    output ram_addr, busy, done, found, index, probes
  );
endinterface

// File: rtl/bsearch_datapath.sv
// Search datapath: latched request, half-open window [lo, hi), probe address and result registers.
module bsearch_datapath
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              accept_s,
  input  logic              issue_s,
  input  logic              compare_s,
  input  logic              finish_s,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] key,
  input  logic [ADDR_W:0]   n,
  input  logic [DATA_W-1:0] ram_data,
  output logic              empty_s,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              found,
  output logic [ADDR_W:0]   index,
  output logic [ADDR_W:0]   probes
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};

  function automatic logic [ADDR_W:0] clamp_n(input logic [ADDR_W:0] raw);
    return (raw > DEPTH_C) ? DEPTH_C : raw;
  endfunction

  logic [DATA_W-1:0] key_r;
  mode_t             mode_r;
  logic [ADDR_W:0]   n_r;
  logic [ADDR_W:0]   lo_r;
  logic [ADDR_W:0]   hi_r;
  logic              hit_r;
  logic [ADDR_W:0]   mid_s;
  logic [ADDR_W-1:0] ram_addr_r;
  logic              found_r;
  logic [ADDR_W:0]   index_r;
  logic [ADDR_W:0]   probes_r;

  assign mid_s   = lo_r + ((hi_r - lo_r) >> 1);
  assign empty_s = (lo_r >= hi_r);

  // Window update; an exact hit collapses the window onto mid so every search ends through ISSUE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_r  <= {DATA_W{1'b0}};
      mode_r <= MODE_EXACT;
      n_r    <= ZERO_C;
      lo_r   <= ZERO_C;
      hi_r   <= ZERO_C;
      hit_r  <= 1'b0;
    end else if (accept_s) begin
      key_r  <= key;
      mode_r <= mode;
      n_r    <= clamp_n(n);
      lo_r   <= ZERO_C;
      hi_r   <= clamp_n(n);
      hit_r  <= 1'b0;
    end else if (compare_s) begin
      if ((mode_r == MODE_EXACT) && (ram_data == key_r)) begin
        lo_r  <= mid_s;
        hi_r  <= mid_s;
        hit_r <= 1'b1;
      end else if (ram_data < key_r) begin
        lo_r <= mid_s + ONE_C;
      end else begin
        hi_r <= mid_s;
      end
    end
  end

  // Probe address, probe count and the held result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_addr_r <= {ADDR_W{1'b0}};
      probes_r   <= ZERO_C;
      index_r    <= ZERO_C;
      found_r    <= 1'b0;
    end else if (accept_s) begin
      probes_r <= ZERO_C;
      index_r  <= ZERO_C;
      found_r  <= 1'b0;
    end else if (issue_s) begin
      ram_addr_r <= mid_s[ADDR_W-1:0];
      probes_r   <= probes_r + ONE_C;
    end else if (finish_s) begin
      index_r <= lo_r;
      found_r <= (mode_r == MODE_LOWER) ? (lo_r < n_r) : hit_r;
    end
  end

  assign ram_addr = ram_addr_r;
  assign found    = found_r;
  assign index    = index_r;
  assign probes   = probes_r;

endmodule

// File: rtl/bsearch_engine.sv
// Binary-search controller over a 1-cycle-latency sorted RAM; datapath lives in bsearch_datapath.
module bsearch_engine
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic     clock,
  input  logic     resetn,
  bsearch_if.slave bus
);

  state_t state_r;
  state_t next_s;
  logic   busy_r;
  logic   done_r;
  logic   accept_s;
  logic   issue_s;
  logic   compare_s;
  logic   finish_s;
  logic   empty_s;

  // State register; busy/done are registered from the next state so they align with it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s == ST_ISSUE) || (next_s == ST_WAIT) || (next_s == ST_COMPARE);
      done_r  <= (next_s == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:    if (bus.start) next_s = ST_ISSUE; else next_s = ST_IDLE;
      ST_ISSUE:   if (empty_s) next_s = ST_DONE; else next_s = ST_WAIT;
      ST_WAIT:    next_s = ST_COMPARE;
      ST_COMPARE: next_s = ST_ISSUE;
      ST_DONE:    if (bus.start) next_s = ST_DONE; else next_s = ST_IDLE;
      default:    next_s = ST_IDLE;
    endcase
  end

  // Datapath control strobes.
  always_comb begin
    accept_s  = 1'b0;
    issue_s   = 1'b0;
    compare_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      ST_IDLE:    accept_s  = bus.start;
      ST_ISSUE: begin
        issue_s  = !empty_s;
        finish_s = empty_s;
      end
      ST_COMPARE: compare_s = 1'b1;
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  bsearch_datapath #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_datapath (
    .clock     (clock),
    .resetn    (resetn),
    .accept_s  (accept_s),
    .issue_s   (issue_s),
    .compare_s (compare_s),
    .finish_s  (finish_s),
    .mode      (bus.mode),
    .key       (bus.key),
    .n         (bus.n),
    .ram_data  (bus.ram_data),
    .empty_s   (empty_s),
    .ram_addr  (bus.ram_addr),
    .found     (bus.found),
    .index     (bus.index),
    .probes    (bus.probes)
  );

  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_bsearch_engine.sv
// Directed bench for bsearch_engine against a RAM holding ram[i] = 3*i.
module tb_bsearch_engine;
  import bsearch_pkg::*;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;
  int   lat;
  int   extra_busy;
  int   missing_done;
  logic [7:0] ram [32];

  bsearch_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  bsearch_engine #(.DATA_W(8), .ADDR_W(5)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) bus.ram_data <= ram[bus.ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a search, scrambles the inputs after accept, returns cycles from accept to Done (-1 on timeout).
  task automatic run(input mode_t m, input logic [7:0] k, input logic [5:0] nn, output int lat_o);
    @(negedge clock);
    bus.mode  = m;
    bus.key   = k;
    bus.n     = nn;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.key  = ~k;
    bus.n    = 6'd1;
    bus.mode = (m == MODE_EXACT) ? MODE_LOWER : MODE_EXACT;
    lat_o = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) begin
        lat_o = c;
        break;
      end
    end
  endtask

  task automatic expect_result(input string tag, input logic f, input logic [5:0] idx,
                               input logic [5:0] p, input int l, input int lat_i);
    check({tag, ".found"},   32'(bus.found),  32'(f));
    check({tag, ".index"},   32'(bus.index),  32'(idx));
    check({tag, ".probes"},  32'(bus.probes), 32'(p));
    check({tag, ".latency"}, 32'(lat_i),      32'(l));
    check({tag, ".busy"},    32'(bus.busy),   32'd0);
  endtask

  task automatic drop_start(input string tag);
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    check({tag, ".idle_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, ".busy"},     32'(bus.busy),     32'd0);
    check({tag, ".done"},     32'(bus.done),     32'd0);
    check({tag, ".found"},    32'(bus.found),    32'd0);
    check({tag, ".index"},    32'(bus.index),    32'd0);
    check({tag, ".probes"},   32'(bus.probes),   32'd0);
    check({tag, ".ram_addr"}, 32'(bus.ram_addr), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) ram[i] = 8'(3 * i);
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.mode  = MODE_EXACT;
    bus.key   = 8'd0;
    bus.n     = 6'd0;
    #1;
    expect_reset_outputs("reset");
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    run(MODE_EXACT, 8'd42, 6'd32, lat);
    expect_result("exact42", 1'b1, 6'd14, 6'd4, 13, lat);
    drop_start("exact42");

    run(MODE_EXACT, 8'd70, 6'd32, lat);
    expect_result("exact70", 1'b0, 6'd24, 6'd5, 16, lat);
    drop_start("exact70");

    run(MODE_LOWER, 8'd70, 6'd32, lat);
    expect_result("lower70", 1'b1, 6'd24, 6'd5, 16, lat);
    drop_start("lower70");

    run(MODE_LOWER, 8'd200, 6'd32, lat);
    expect_result("lower200", 1'b0, 6'd32, 6'd5, 16, lat);
    drop_start("lower200");

    // Last probe above was address 31; an empty search must leave it untouched.
    run(MODE_EXACT, 8'd42, 6'd0, lat);
    expect_result("n0", 1'b0, 6'd0, 6'd0, 1, lat);
    check("n0.ram_addr", 32'(bus.ram_addr), 32'd31);
    drop_start("n0");

    run(MODE_LOWER, 8'd0, 6'd32, lat);
    expect_result("lower0", 1'b1, 6'd0, 6'd6, 19, lat);
    drop_start("lower0");

    run(MODE_EXACT, 8'd42, 6'd40, lat);
    expect_result("n40", 1'b1, 6'd14, 6'd4, 13, lat);
    drop_start("n40");

    run(MODE_EXACT, 8'd42, 6'd32, lat);
    expect_result("held", 1'b1, 6'd14, 6'd4, 13, lat);
    extra_busy   = 0;
    missing_done = 0;
    repeat (27) begin
      @(posedge clock);
      #1;
      if (bus.busy !== 1'b0) extra_busy++;
      if (bus.done !== 1'b1) missing_done++;
    end
    check("held.extra_busy",   32'(extra_busy),   32'd0);
    check("held.missing_done", 32'(missing_done), 32'd0);
    check("held.probes",       32'(bus.probes),   32'd4);
    drop_start("held");

    run(MODE_EXACT, 8'd3, 6'd32, lat);
    expect_result("key3", 1'b1, 6'd1, 6'd5, 16, lat);
    drop_start("key3");

    @(negedge clock);
    bus.mode  = MODE_EXACT;
    bus.key   = 8'd42;
    bus.n     = 6'd32;
    bus.start = 1'b1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    check("midrst.busy",     32'(bus.busy),     32'd1);
    check("midrst.probes",   32'(bus.probes),   32'd2);
    check("midrst.ram_addr", 32'(bus.ram_addr), 32'd8);
    resetn    = 1'b0;
    bus.start = 1'b0;
    #1;
    expect_reset_outputs("midrst");
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    expect_reset_outputs("midrst.idle");

    run(MODE_EXACT, 8'd42, 6'd32, lat);
    expect_result("after_rst", 1'b1, 6'd14, 6'd4, 13, lat);
    drop_start("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
